hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Hazard detection and stall sequencer for the 5-stage pipeline, with branches resolved in ID.
- Produces the stall_o bubble request that the ID-stage control-zeroing mux consumes. It also produces PC/IF-ID write enables, the IF/ID flush, and a whole-pipe freeze for data-memory wait.
- Multi-bubble hazards (load feeding an ID-stage branch) are sequenced by an internal FSM and down-counter.
- Saturating performance counters record stall and flush cycles.

Parameters:
REG_ADDR_W, 5, register address width
BRANCH_LOAD_BUBBLES, 2, bubbles inserted when an EX-stage load feeds an ID-stage branch (legal range 1..3)
CNT_W, 32, performance counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
IFID_RegisterRs1_i  in  REG_ADDR_W  rs1 of instruction in ID
IFID_RegisterRs2_i  in  REG_ADDR_W  rs2 of instruction in ID
IFID_Branch_i  in  1  instruction in ID is a branch
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_RegWrite_i  in  1  instruction in EX writes a register
IDEX_RegisterRd_i  in  REG_ADDR_W  rd of instruction in EX
Branch_taken_i  in  1  ID-stage branch comparison result (taken)
mem_stall_i  in  1  data memory busy; pipeline must freeze
stall_o  out  1  insert bubble into ID/EX (zero control)
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID register write enable
IFID_flush_o  out  1  clear IF/ID to NOP
freeze_o  out  1  hold all pipeline registers
stall_cnt_o  out  CNT_W  bubble cycles inserted
flush_cnt_o  out  CNT_W  flush cycles issued

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. Clock port is clk_i and reset port is rst_i.
- Reset state:
  - state=RUN, remaining=0, both counters=0.
  - While rst_i=1, outputs are forced to: stall_o=0, PCWrite_o=1, IFIDWrite_o=1, IFID_flush_o=0, freeze_o=0.
- Hazard detection is combinational from the inputs. Define match = IDEX_RegisterRd_i!=0 && (Rd==rs1 || Rd==rs2). A destination of x0 never matches.
  - load_use = IDEX_MemRead_i && match.
  - alu_branch = IFID_Branch_i && IDEX_RegWrite_i && !IDEX_MemRead_i && match.
- Bubble count needed on detection:
  - load_use with IFID_Branch_i=1: BRANCH_LOAD_BUBBLES.
  - load_use otherwise: 1.
  - alu_branch: 1.
- FSM states: RUN, BUBBLE.
- RUN, hazard detected:
  - Outputs in the same cycle (Mealy, zero latency): stall_o=1, PCWrite_o=0, IFIDWrite_o=0.
  - If needed>1: next state BUBBLE, remaining=needed-1.
  - Otherwise: stay in RUN.
- BUBBLE:
  - stall_o=1, PCWrite_o=0, IFIDWrite_o=0 regardless of the inputs. ID/EX now holds a bubble, so detection is not used here.
  - Each unfrozen cycle, remaining decrements. When remaining reaches 1, the transition is to RUN (re-detection happens in RUN on the next cycle).
- Freeze (mem_stall_i=1) has highest priority, in any state:
  - Outputs: freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, stall_o=0, IFID_flush_o=0.
  - State, remaining and both counters hold.
  - A hazard present during freeze is acted on in the first unfrozen cycle.
- Branch flush: IFID_flush_o = Branch_taken_i && !stall_o && !freeze_o. Branch_taken_i is ignored while stalling, because operands are not yet valid.
- Counters:
  - stall_cnt_o increments in every cycle with stall_o=1.
  - flush_cnt_o increments in every cycle with IFID_flush_o=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Simultaneous events:
  - freeze beats stall, and stall beats flush.
  - Reset during BUBBLE returns to RUN the next cycle with counters cleared; no residual bubble.
- Default outputs (no event): stall_o=0, PCWrite_o=1, IFIDWrite_o=1, IFID_flush_o=0, freeze_o=0.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, BUBBLE};
  - REG_ADDR_W;
  - default BRANCH_LOAD_BUBBLES;
  - the x0 register address constant.
- One sub-module, sat_counter (parameter CNT_W; inputs clk_i, rst_i, inc_i; output count_o), instantiated twice for the performance counters.

Test Plan:
- Load-use: EX holds lw x5 (MemRead=1, Rd=5) and ID holds add rs1=5 -> stall_o=1, PCWrite_o=0, IFIDWrite_o=0 for exactly 1 cycle; stall_cnt_o=1.
- Load feeding branch: EX holds lw x6 and ID holds beq rs2=6 (Branch=1) -> stall_o=1 for 2 consecutive cycles, then RUN. Branch_taken_i=1 is held throughout, so IFID_flush_o=1 only in cycle 3; flush_cnt_o=1.
- ALU feeding branch, and x0: EX holds add x7 (RegWrite=1) with ID beq rs1=7 -> 1 bubble. Same pattern with Rd=0 -> no stall.
- Freeze mid-bubble: during the load-branch case, mem_stall_i=1 for 3 cycles after the first bubble -> freeze_o=1 and stall_o=0 for those 3 cycles. Exactly 1 more bubble follows the release; stall_cnt_o=2.
- Reset mid-bubble: rst_i=1 for one cycle in BUBBLE -> next cycle stall_o=0, PCWrite_o=1, both counters 0.
- Saturation: CNT_W=4, hold a load-use hazard for 20 cycles -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall control slice:
//   - state_e             : stall sequencer states (RUN, BUBBLE)
//   - REG_ADDR_W          : register address width
//   - BRANCH_LOAD_BUBBLES_DEF : default bubble count for load -> ID-branch
//   - REG_X0              : address of the hard-wired zero register
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_e;

    localparam int REG_ADDR_W              = 5;
    localparam int BRANCH_LOAD_BUBBLES_DEF = 2;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

endpackage : pipe_ctrl_pkg

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count, sticks at all-ones instead of wrapping
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
// Hazard detection and stall sequencer for a 5-stage pipeline that resolves
// branches in ID. Detects load-use and ALU->ID-branch hazards, sequences
// multi-bubble stalls, freezes the pipe on data-memory wait, flushes IF/ID on
// taken branches and keeps saturating stall/flush cycle counters.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   IFID_RegisterRs1/Rs2_i       : source registers of the ID instruction
//   IFID_Branch_i                : ID instruction is a branch
//   IDEX_MemRead_i/RegWrite_i    : EX instruction is a load / writes a reg
//   IDEX_RegisterRd_i            : destination of the EX instruction
//   Branch_taken_i               : ID-stage branch outcome
//   mem_stall_i                  : data memory busy, freeze everything
//   stall_o                      : zero ID/EX control (insert bubble)
//   PCWrite_o, IFIDWrite_o       : PC and IF/ID write enables
//   IFID_flush_o                 : clear IF/ID to NOP
//   freeze_o                     : hold all pipeline registers
//   stall_cnt_o, flush_cnt_o     : bubble / flush cycle counters
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W          = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int BRANCH_LOAD_BUBBLES = pipe_ctrl_pkg::BRANCH_LOAD_BUBBLES_DEF,
    parameter int CNT_W               = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] IFID_RegisterRs1_i,
    input  logic [REG_ADDR_W-1:0] IFID_RegisterRs2_i,
    input  logic                  IFID_Branch_i,
    input  logic                  IDEX_MemRead_i,
    input  logic                  IDEX_RegWrite_i,
    input  logic [REG_ADDR_W-1:0] IDEX_RegisterRd_i,
    input  logic                  Branch_taken_i,
    input  logic                  mem_stall_i,
    output logic                  stall_o,
    output logic                  PCWrite_o,
    output logic                  IFIDWrite_o,
    output logic                  IFID_flush_o,
    output logic                  freeze_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    // Bubble count never exceeds 3, so two bits of remaining are enough.
    localparam int REM_W = 2;

    state_e           state_d, state_q;
    logic [REM_W-1:0] remaining_d, remaining_q;

    logic             match_s;
    logic             load_use_s;
    logic             alu_branch_s;
    logic             hazard_s;
    logic [REM_W-1:0] needed_s;

    // Hazard detection; a write to x0 can never create a dependency.
    always_comb begin
        match_s      = (IDEX_RegisterRd_i != REG_X0[REG_ADDR_W-1:0]) &&
                       ((IDEX_RegisterRd_i == IFID_RegisterRs1_i) ||
                        (IDEX_RegisterRd_i == IFID_RegisterRs2_i));
        load_use_s   = IDEX_MemRead_i && match_s;
        alu_branch_s = IFID_Branch_i && IDEX_RegWrite_i && !IDEX_MemRead_i && match_s;
        hazard_s     = load_use_s || alu_branch_s;
        if (load_use_s && IFID_Branch_i) begin
            needed_s = REM_W'(BRANCH_LOAD_BUBBLES);
        end else begin
            needed_s = 2'd1;
        end
    end

    // Sequencer next state and Mealy outputs; freeze outranks everything.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        stall_o      = 1'b0;
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        freeze_o     = 1'b0;
        if (rst_i) begin
            state_d     = RUN;
            remaining_d = 2'd0;
        end else if (mem_stall_i) begin
            // Everything holds; a pending hazard is seen again once released.
            freeze_o    = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_s) begin
                        stall_o     = 1'b1;
                        PCWrite_o   = 1'b0;
                        IFIDWrite_o = 1'b0;
                        if (needed_s > 2'd1) begin
                            state_d     = BUBBLE;
                            remaining_d = needed_s - 2'd1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                BUBBLE: begin
                    // ID/EX holds a bubble, so detection results are stale here.
                    stall_o     = 1'b1;
                    PCWrite_o   = 1'b0;
                    IFIDWrite_o = 1'b0;
                    if (remaining_q <= 2'd1) begin
                        state_d     = RUN;
                        remaining_d = 2'd0;
                    end else begin
                        remaining_d = remaining_q - 2'd1;
                    end
                end
                default: begin
                    state_d     = RUN;
                    remaining_d = 2'd0;
                end
            endcase
        end
        // Branch operands are not valid while stalling, so no flush then.
        IFID_flush_o = Branch_taken_i && !stall_o && !freeze_o && !rst_i;
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            remaining_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (stall_o),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (IFID_flush_o),
        .count_o (flush_cnt_o)
    );

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Scoreboard bench: each step drives one cycle of pipeline inputs, pushes the
// expected outputs, then pops and compares them before the next clock edge.
// A second instance with 4-bit counters shares the inputs to show saturation.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        br, mr, rw, bt, ms;

    logic        stall, pcw, ifidw, flush, freeze;
    logic [31:0] scnt, fcnt;
    logic        stall4, pcw4, ifidw4, flush4, freeze4;
    logic [3:0]  scnt4, fcnt4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        stall, pcw, ifidw, flush, freeze;
        logic [31:0] scnt, fcnt;
        logic [3:0]  scnt4;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_scnt, m_fcnt;
    logic [3:0]  m_scnt4;

    hazard_stall_ctrl u_dut (
        .clk_i(clk), .rst_i(rst),
        .IFID_RegisterRs1_i(rs1), .IFID_RegisterRs2_i(rs2), .IFID_Branch_i(br),
        .IDEX_MemRead_i(mr), .IDEX_RegWrite_i(rw), .IDEX_RegisterRd_i(rd),
        .Branch_taken_i(bt), .mem_stall_i(ms),
        .stall_o(stall), .PCWrite_o(pcw), .IFIDWrite_o(ifidw),
        .IFID_flush_o(flush), .freeze_o(freeze),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    hazard_stall_ctrl #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .IFID_RegisterRs1_i(rs1), .IFID_RegisterRs2_i(rs2), .IFID_Branch_i(br),
        .IDEX_MemRead_i(mr), .IDEX_RegWrite_i(rw), .IDEX_RegisterRd_i(rd),
        .Branch_taken_i(bt), .mem_stall_i(ms),
        .stall_o(stall4), .PCWrite_o(pcw4), .IFIDWrite_o(ifidw4),
        .IFID_flush_o(flush4), .freeze_o(freeze4),
        .stall_cnt_o(scnt4), .flush_cnt_o(fcnt4)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at falling edge, score before the next rising edge.
    task automatic drive(input string tag,
                         input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                         input logic i_br, input logic i_mr, input logic i_rw,
                         input logic [4:0] i_rd, input logic i_bt,
                         input logic i_ms, input logic i_rst,
                         input logic e_stall, input logic e_freeze, input logic e_flush);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rs1 = i_rs1; rs2 = i_rs2; br = i_br; mr = i_mr; rw = i_rw;
        rd = i_rd; bt = i_bt; ms = i_ms; rst = i_rst;
        e.stall  = e_stall;
        e.freeze = e_freeze;
        e.flush  = e_flush;
        e.pcw    = !(e_stall || e_freeze);
        e.ifidw  = !(e_stall || e_freeze);
        e.scnt   = m_scnt;
        e.fcnt   = m_fcnt;
        e.scnt4  = m_scnt4;
        sb_q.push_back(e);
        #2;
        if (sb_q.size() == 0) begin
            chk_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sb_q.pop_front();
            chk_eq({tag, ".stall"},  {31'd0, stall},  {31'd0, g.stall});
            chk_eq({tag, ".pcw"},    {31'd0, pcw},    {31'd0, g.pcw});
            chk_eq({tag, ".ifidw"},  {31'd0, ifidw},  {31'd0, g.ifidw});
            chk_eq({tag, ".flush"},  {31'd0, flush},  {31'd0, g.flush});
            chk_eq({tag, ".freeze"}, {31'd0, freeze}, {31'd0, g.freeze});
            chk_eq({tag, ".scnt"},   scnt, g.scnt);
            chk_eq({tag, ".fcnt"},   fcnt, g.fcnt);
            chk_eq({tag, ".scnt4"},  {28'd0, scnt4}, {28'd0, g.scnt4});
        end
        // Counter model for the values visible next cycle.
        if (i_rst) begin
            m_scnt = 32'd0; m_fcnt = 32'd0; m_scnt4 = 4'd0;
        end else begin
            if (e_stall) begin
                m_scnt = m_scnt + 32'd1;
                if (m_scnt4 != 4'd15) m_scnt4 = m_scnt4 + 4'd1;
            end
            if (e_flush) m_fcnt = m_fcnt + 32'd1;
        end
    endtask

    initial begin
        rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        br = 1'b0; mr = 1'b0; rw = 1'b0; bt = 1'b0; ms = 1'b0;
        m_scnt = 32'd0; m_fcnt = 32'd0; m_scnt4 = 4'd0;
        repeat (2) @(posedge clk);

        //     tag        rs1    rs2    br    mr    rw    rd     bt    ms    rst   stall frz   flush
        drive("reset",    5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("idle",     5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load-use: exactly one bubble.
        drive("lu_hit",   5'd5,  5'd1,  1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("lu_after", 5'd5,  5'd1,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load feeding branch: two bubbles, flush only on the third cycle.
        drive("lb_b1",    5'd1,  5'd6,  1'b1, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("lb_b2",    5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("lb_fl",    5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive("lb_idle",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // ALU feeding branch: one bubble; x0 destination never stalls.
        drive("ab_hit",   5'd7,  5'd2,  1'b1, 1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("ab_fl",    5'd7,  5'd2,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive("ab_x0",    5'd0,  5'd2,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("lu_x0",    5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Freeze in RUN with a hazard pending: acted on after release.
        drive("fz_run",   5'd9,  5'd1,  1'b0, 1'b1, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("fz_rel",   5'd9,  5'd1,  1'b0, 1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("fz_done",  5'd9,  5'd1,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Freeze mid-bubble: three frozen cycles, then one remaining bubble.
        drive("fb_b1",    5'd1,  5'd6,  1'b1, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive("fb_frz", 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        drive("fb_b2",    5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("fb_fl",    5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Reset mid-bubble: no residual bubble, counters cleared.
        drive("rb_b1",    5'd1,  5'd6,  1'b1, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("rb_rst",   5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("rb_after", 5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Held load-use hazard: 32-bit count reaches 20, 4-bit stops at 15.
        for (int i = 0; i < 20; i++) begin
            drive("sat",  5'd4,  5'd0,  1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        drive("sat_end",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("sat_final4", {28'd0, scnt4}, 32'd15);
        chk_eq("sat_final32", scnt, 32'd20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
